// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment display scan path:
// digit count, nibble width and the scan FSM state type.
package display_pkg;

    localparam int N_DIGITS = 8;
    localparam int NIBBLE_W = 4;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/lz_mask_gen.sv
// Leading-zero visibility mask: bit k is set when digit k is at or below the
// most significant non-zero nibble. Digit 0 is always eligible so an all-zero
// value still shows a single "0". Only instantiated when LEADING_ZERO_BLANK_EN
// is defined in the top level.
module lz_mask_gen
    import display_pkg::*;
(
    input  logic [N_DIGITS*NIBBLE_W-1:0] value,
    output logic [N_DIGITS-1:0]          mask
);

    // Scan from the top digit down, latching once a non-zero nibble is seen.
    always_comb begin
        logic seen;
        seen = 1'b0;
        mask = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            seen    = seen | (|value[k*NIBBLE_W +: NIBBLE_W]);
            mask[k] = seen;
        end
        mask[0] = 1'b1;
    end

endmodule

// File: rtl/display_scan_controller.sv
// Digit sequencer for the 8-digit multiplexed seven-segment display.
// Produces the nibble-mux select (counter), active-low anodes with a blanking
// gap at the start of every digit slot, and a double-buffered display value
// that only changes on a frame boundary (load / load_ack handshake).
// Optional feature: define LEADING_ZERO_BLANK_EN to also blank digits above
// the most significant non-zero nibble of the committed value.
//
// Every output is a register loaded from the next-state values, so the
// boundary cycle (slot_cnt == REFRESH_DIV-1 with counter == 7) already shows
// frame_tick, load_ack and the newly committed hex_out.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hex_in,
    input  logic [7:0]  digit_en_in,
    input  logic        load,
    output logic        load_ack,
    output logic [31:0] hex_out,
    output logic [2:0]  counter,
    output logic [7:0]  an,
    output logic        frame_tick
);

    localparam int                SLOT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]        LAST_DIGIT = 3'(N_DIGITS - 1);

    scan_state_t       state;
    scan_state_t       state_n;
    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] slot_n;
    logic [2:0]        counter_n;

    logic [31:0]       stage_hex;
    logic [7:0]        stage_en;
    logic [31:0]       stage_hex_n;
    logic [7:0]        stage_en_n;
    logic              pending;
    logic              pending_n;
    logic [7:0]        digit_en;

    logic              boundary_n;
    logic              commit_n;
    logic [31:0]       hex_n;
    logic [7:0]        digit_en_n;
    logic [7:0]        shown_n;
    logic [7:0]        an_n;

    // Scan FSM next state: slot counter, digit index and blank/on phase.
    always_comb begin
        state_n   = state;
        slot_n    = slot_cnt + 1'b1;
        counter_n = counter;
        if (slot_cnt == SLOT_LAST) begin
            slot_n    = '0;
            counter_n = counter + 3'd1;
            state_n   = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;
        end else if (state == S_BLANK &&
                     (BLANK_CYCLES == 0 || slot_cnt == BLANK_LAST)) begin
            state_n = S_ON;
        end
    end

    // Staging capture and commit decision for the cycle about to begin.
    // A load in the cycle just before the boundary still commits at it; a
    // load during the boundary cycle itself waits for the next frame.
    always_comb begin
        boundary_n  = (slot_n == SLOT_LAST) && (counter_n == LAST_DIGIT);
        stage_hex_n = load ? hex_in      : stage_hex;
        stage_en_n  = load ? digit_en_in : stage_en;
        commit_n    = boundary_n && (pending || load);
        pending_n   = commit_n ? 1'b0 : (pending || load);
        hex_n       = commit_n ? stage_hex_n : hex_out;
        digit_en_n  = commit_n ? stage_en_n  : digit_en;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] lz_mask_n;

    lz_mask_gen u_lz_mask_gen (
        .value (hex_n),
        .mask  (lz_mask_n)
    );

    assign shown_n = digit_en_n & lz_mask_n;
`else
    assign shown_n = digit_en_n;
`endif

    // Anode pattern for the next cycle: one active-low digit while on, else dark.
    always_comb begin
        an_n = 8'hFF;
        if (state_n == S_ON && shown_n[counter_n]) begin
            an_n = ~(8'b1 << counter_n);
        end
    end

    // State and output registers; reset drops any pending load without ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_BLANK;
            slot_cnt   <= '0;
            counter    <= 3'd0;
            an         <= 8'hFF;
            frame_tick <= 1'b0;
            load_ack   <= 1'b0;
            pending    <= 1'b0;
            stage_hex  <= 32'd0;
            stage_en   <= 8'd0;
            hex_out    <= 32'd0;
            digit_en   <= 8'hFF;
        end else begin
            state      <= state_n;
            slot_cnt   <= slot_n;
            counter    <= counter_n;
            an         <= an_n;
            frame_tick <= boundary_n;
            load_ack   <= commit_n;
            pending    <= pending_n;
            stage_hex  <= stage_hex_n;
            stage_en   <= stage_en_n;
            hex_out    <= hex_n;
            digit_en   <= digit_en_n;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (REFRESH_DIV=10, BLANK_CYCLES=2).
// The driver computes each cycle's expected outputs from the cycle index since
// reset and a simple load/commit model, pushing them into a queue; a monitor
// pops one entry per cycle and compares against the DUT.
module tb_display_scan_controller;

    localparam int RD    = 10;
    localparam int BC    = 2;
    localparam int FRAME = 8 * RD;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hex_in;
    logic [7:0]  digit_en_in;
    logic        load;
    logic        load_ack;
    logic [31:0] hex_out;
    logic [2:0]  counter;
    logic [7:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    display_scan_controller #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hex_in      (hex_in),
        .digit_en_in (digit_en_in),
        .load        (load),
        .load_ack    (load_ack),
        .hex_out     (hex_out),
        .counter     (counter),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    typedef struct {
        int          t;
        logic [7:0]  an;
        logic [2:0]  cnt;
        logic [31:0] hex;
        logic        ack;
        logic        tick;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int          t;
    logic        pend;
    logic [31:0] st_hex;
    logic [7:0]  st_en;
    logic [31:0] cm_hex;
    logic [7:0]  cm_en;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [7:0] lz_ref(input logic [31:0] v);
        int h;
        logic [8:0] m;
        h = 0;
        for (int k = 0; k < 8; k++) if (((v >> (4 * k)) & 32'hF) != 0) h = k;
        m = (9'd1 << (h + 1)) - 9'd1;
        return m[7:0];
    endfunction
`endif

    // One clock cycle: predict this cycle's outputs, drive inputs, advance model.
    task automatic step(input logic ld, input logic [31:0] h, input logic [7:0] m,
                        input logic rst);
        exp_t e;
        int slot, dig;
        logic [7:0] shown;
        e.ack = 1'b0;
        if ((t % FRAME) == FRAME - 1 && pend) begin
            cm_hex = st_hex;
            cm_en  = st_en;
            pend   = 1'b0;
            e.ack  = 1'b1;
        end
        slot  = t % RD;
        dig   = (t / RD) % 8;
        shown = cm_en;
`ifdef LEADING_ZERO_BLANK_EN
        shown = shown & lz_ref(cm_hex);
`endif
        e.t    = t;
        e.cnt  = 3'(dig);
        e.hex  = cm_hex;
        e.tick = ((t % FRAME) == FRAME - 1);
        e.an   = (slot >= BC && shown[dig]) ? ~(8'd1 << dig) : 8'hFF;
        q.push_back(e);

        reset       = rst;
        load        = ld;
        hex_in      = h;
        digit_en_in = m;
        if (rst) begin
            t      = 0;
            pend   = 1'b0;
            st_hex = 32'd0;
            st_en  = 8'd0;
            cm_hex = 32'd0;
            cm_en  = 8'hFF;
        end else begin
            if (ld) begin
                st_hex = h;
                st_en  = m;
                pend   = 1'b1;
            end
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, $urandom, 8'($urandom), 1'b0);
    endtask

    task automatic run_to(input int phase);
        while ((t % FRAME) != phase) idle();
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            n_checks++;
            if ({an, counter, hex_out, load_ack, frame_tick} ===
                {cur.an, cur.cnt, cur.hex, cur.ack, cur.tick}) begin
                n_pass++;
            end else begin
                $display("FAIL cycle t=%0d: got an=%h counter=%0d hex_out=%h load_ack=%b frame_tick=%b, expected an=%h counter=%0d hex_out=%h load_ack=%b frame_tick=%b",
                         cur.t, an, counter, hex_out, load_ack, frame_tick,
                         cur.an, cur.cnt, cur.hex, cur.ack, cur.tick);
            end
        end
    end

    initial begin
        int r;
        reset       = 1'b1;
        load        = 1'b0;
        hex_in      = 32'd0;
        digit_en_in = 8'd0;
        t           = 0;
        pend        = 1'b0;
        st_hex      = 32'd0;
        st_en       = 8'd0;
        cm_hex      = 32'd0;
        cm_en       = 8'hFF;
        repeat (2) @(posedge clk);
        #1;

        // Free-running frame straight out of reset
        repeat (FRAME) idle();

        // Single load mid-frame, committed at the boundary
        run_to(5);
        step(1'b1, 32'h1234_5678, 8'hFF, 1'b0);
        run_to(0);

        // Two loads in one frame: last wins, one ack
        run_to(10);
        step(1'b1, 32'hAAAA_AAAA, 8'hFF, 1'b0);
        run_to(40);
        step(1'b1, 32'h5555_5555, 8'hFF, 1'b0);
        run_to(0);

        // Load on the boundary cycle with nothing pending: acked a frame later
        run_to(FRAME - 1);
        step(1'b1, 32'hCAFE_F00D, 8'hFF, 1'b0);
        repeat (FRAME + 2) idle();

        // Load in the cycle just before the boundary: minimum latency
        run_to(FRAME - 2);
        step(1'b1, 32'h0BAD_CAFE, 8'hFF, 1'b0);
        run_to(0);

        // Sparse digit mask
        run_to(20);
        step(1'b1, 32'h8765_4321, 8'b0000_0101, 1'b0);
        run_to(0);
        repeat (FRAME) idle();

        // Small value with all digits enabled
        run_to(20);
        step(1'b1, 32'h0000_00A3, 8'hFF, 1'b0);
        run_to(0);
        repeat (FRAME) idle();

        // Reset in slot 4 with a load pending: load is dropped
        run_to(25);
        step(1'b1, 32'hDEAD_BEEF, 8'h3C, 1'b0);
        run_to(45);
        step(1'b0, 32'd0, 8'd0, 1'b1);
        repeat (FRAME + 5) idle();

        // Randomized loads, masks and occasional resets
        repeat (2000) begin
            r = $urandom_range(0, 999);
            step(r < 25, $urandom, 8'($urandom), r == 999);
        end
        repeat (FRAME) idle();

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Sequencer for the 8-digit multiplexed seven-segment display. Generates the 3-bit digit-select `counter` consumed by the existing nibble mux, drives the active-low anodes with an inter-digit blanking gap, and double-buffers the 32-bit hex value with a load/acknowledge handshake so the shown value only changes on a frame boundary. Sits between the application logic and the nibble-mux/segment-decoder path.

## Interface
- `REFRESH_DIV`, 100_000: clock cycles per digit slot (1 kHz/digit at 100 MHz); must be ≥ 2.
- `BLANK_CYCLES`, 1_000: cycles at the start of each slot with all anodes off; 0 ≤ BLANK_CYCLES < REFRESH_DIV; 0 removes the blank phase.

- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `hex_in` in 32: value to display, nibble k → digit k.
- `digit_en_in` in 8: per-digit enable mask, sampled together with `hex_in`.
- `load` in 1: single-cycle request; samples `hex_in`/`digit_en_in` into staging.
- `load_ack` out 1: one-cycle pulse when staging is committed to the display register.
- `hex_out` out 32: committed display value, feeds the nibble mux data input.
- `counter` out 3: current digit index, feeds the nibble mux select.
- `an` out 8: anodes, active-low, at most one bit low.
- `frame_tick` out 1: one-cycle pulse when `counter` wraps 7→0.

## Operation
- FSM `scan_state_t`: S_BLANK, S_ON. Slot counter `slot_cnt` counts 0..REFRESH_DIV-1 every cycle.
- S_BLANK: `an` = 8'hFF. When `slot_cnt` == BLANK_CYCLES-1 → S_ON.
- S_ON: `an` = ~(8'b1 << counter) if digit `counter` is shown, else 8'hFF.
- Slot end (`slot_cnt` == REFRESH_DIV-1): `slot_cnt` → 0, `counter` → counter+1 (wrap 7→0), state → S_BLANK (→ S_ON directly if BLANK_CYCLES = 0).
- Frame boundary = slot end with `counter` == 7; `frame_tick` pulses that cycle.
- Load: on `load`=1, staging ← {`digit_en_in`, `hex_in`}, `pending` ← 1. Repeat loads before commit overwrite staging (last wins); only one ack.
- Commit: at frame boundary with `pending` already 1 (set in an earlier cycle): display regs ← staging, `pending` ← 0, `load_ack` = 1 that cycle.
- `load` coincident with a frame boundary: staging captured that cycle counts toward the next boundary; if `pending` was already set, old staging commits and acks, and `pending` stays 1 for the new data.
- Digit shown = committed `digit_en` bit (AND leading-zero mask when configured).

## Timing
- All outputs registered; `an`, `counter`, `hex_out`, `load_ack`, `frame_tick` change on the same edge as the state they reflect.
- Reset values: `counter`=0, `an`=8'hFF, state S_BLANK, `slot_cnt`=0, `hex_out`=0, committed `digit_en`=8'hFF, staging=0, `pending`=0, `load_ack`=0, `frame_tick`=0.
- Reset mid-frame or with a load pending: pending load discarded, no ack.
- Frame period = 8·REFRESH_DIV cycles; load-to-ack latency 1..8·REFRESH_DIV cycles.
- `slot_cnt` width = $clog2(REFRESH_DIV).

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: digits above the most significant non-zero nibble of `hex_out` are forced off in addition to `digit_en`; digit 0 always eligible (value 0 shows a single "0").
- Undefined: visibility governed by `digit_en` only; no mask logic synthesised.

## Structure
- Package `display_pkg`: `N_DIGITS`=8, `NIBBLE_W`=4, `scan_state_t` enum.
- One sub-module `lz_mask_gen` (combinational, 32-bit in → 8-bit mask), instantiated only under `LEADING_ZERO_BLANK_EN`.

## Test plan
Use REFRESH_DIV=10, BLANK_CYCLES=2 (frame = 80 cycles).
- Reset, then free-run 80 cycles → `an` sequence per slot: 2 cycles 8'hFF, 8 cycles 8'hFE, 8'hFD … 8'h7F; `counter` 0..7; `frame_tick` once at cycle 79.
- `load` with 32'h1234_5678, mask 8'hFF at cycle 5 → `hex_out` unchanged until the frame boundary at cycle 79, then 32'h1234_5678 with `load_ack` single pulse that cycle.
- Two loads (32'hAAAA_AAAA then 32'h5555_5555) in one frame → one ack, `hex_out` = 32'h5555_5555.
- `load` exactly on a frame-boundary cycle with `pending`=0 → no ack that boundary; commit and ack at the next boundary 80 cycles later.
- Mask 8'b0000_0101 → anodes low only in slots 0 and 2; other slots all 8'hFF. With `LEADING_ZERO_BLANK_EN`, value 32'h0000_00A3 and mask 8'hFF → only digits 0,1 light.
- Assert `reset` mid-slot 4 with load pending → next cycle `an`=8'hFF, `counter`=0; no `load_ack` ever for that load.
